// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared constants and types for the LED pattern sequencer and
//                the LED fade driver. Provides channel count, PWM resolution,
//                default prescaler divisors, the system clock rate and a
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int NUM_LED          = 4;
    localparam int PWM_BITS         = 8;
    localparam int CLK_HZ           = 50_000_000;
    // 50 MHz / 196 / 256 ~= 1 kHz PWM frame.
    localparam int PWM_DIV_DEFAULT  = 196;
    // 256 fade steps ~= 1 s full-scale ramp at 50 MHz.
    localparam int FADE_DIV_DEFAULT = 195_313;

    // Per-channel level update decision for one cycle.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_JUMP = 2'd3
    } step_e;

    // Width of a prescaler counting 0..div-1; never less than one bit so a
    // divide-by-one prescaler still has a legal (constant-zero) register.
    function automatic int ctr_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_channel
//  Description : One LED channel: brightness level register that either jumps
//                to or ramps (one step per fade tick) toward its target, plus
//                the PWM comparator and registered pin drive.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_req           - channel requested on
//                i_max_level     - brightness of an "on" channel
//                i_fade_en       - 1 = ramp, 0 = jump to target
//                i_fade_tick     - one-cycle fade step strobe
//                i_pwm_cnt       - shared free-running PWM counter
//                o_pwm           - registered PWM drive
//                o_pending       - next level differs from target (comb.)
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = led_pkg::PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [PWM_BITS-1:0] i_max_level,
    input  logic                i_fade_en,
    input  logic                i_fade_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_pwm,
    output logic                o_pending
);

    logic [PWM_BITS-1:0] r_level;
    logic                r_pwm;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS-1:0] w_level_next;
    step_e               w_step;

    always_comb begin
        w_target = i_req ? i_max_level : '0;
        w_step   = STEP_HOLD;
        if (!i_fade_en) begin
            w_step = STEP_JUMP;
        end else if (i_fade_tick) begin
            // Stepping only toward a target inside the level range means the
            // level can never pass 0 or all-ones, so no wrap guard is needed.
            if (r_level < w_target) begin
                w_step = STEP_UP;
            end else if (r_level > w_target) begin
                w_step = STEP_DOWN;
            end
        end
    end

    always_comb begin
        w_level_next = r_level;
        case (w_step)
            STEP_UP:   w_level_next = r_level + PWM_BITS'(1);
            STEP_DOWN: w_level_next = r_level - PWM_BITS'(1);
            STEP_JUMP: w_level_next = w_target;
            default:   w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_level <= w_level_next;
            // Full-scale is forced high so the LED is truly constant-on
            // instead of dropping out for the one count where cnt==all-ones.
            r_pwm   <= (r_level == '1) || (r_level > i_pwm_cnt);
        end
    end

    assign o_pwm     = r_pwm;
    assign o_pending = (w_level_next != w_target);

endmodule : led_pwm_channel
`default_nettype wire

// File: rtl/led_fade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_driver
//  Description : Drives the board LEDs from the pattern sequencer's request
//                through per-channel PWM with smooth fade-in/fade-out. Holds
//                the shared PWM and fade prescalers, the free-running PWM
//                counter and the registered busy flag.
//  Ports       : clk        - system clock (50 MHz)
//                rst        - synchronous active-high reset
//                led_req    - requested LED on/off pattern
//                max_level  - brightness of an "on" LED
//                fade_en    - 1 = ramp toward target, 0 = jump
//                led_pwm    - registered PWM drive to LED pins
//                busy       - registered: some channel not yet at target
//  Revision    : 1.0 - initial release
// ============================================================================
module led_fade_driver
    import led_pkg::*;
#(
    parameter int NUM_LED  = led_pkg::NUM_LED,
    parameter int PWM_BITS = led_pkg::PWM_BITS,
    parameter int PWM_DIV  = led_pkg::PWM_DIV_DEFAULT,
    parameter int FADE_DIV = led_pkg::FADE_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LED-1:0]  led_req,
    input  logic [PWM_BITS-1:0] max_level,
    input  logic                fade_en,
    output logic [NUM_LED-1:0]  led_pwm,
    output logic                busy
);

    localparam int c_pwm_pre_w  = ctr_width(PWM_DIV);
    localparam int c_fade_pre_w = ctr_width(FADE_DIV);
    localparam logic [c_pwm_pre_w-1:0]  c_pwm_term  = c_pwm_pre_w'(PWM_DIV - 1);
    localparam logic [c_fade_pre_w-1:0] c_fade_term = c_fade_pre_w'(FADE_DIV - 1);

    logic [c_pwm_pre_w-1:0]  r_pwm_pre;
    logic [c_fade_pre_w-1:0] r_fade_pre;
    logic [PWM_BITS-1:0]     r_pwm_cnt;
    logic                    r_busy;
    logic                    w_pwm_tick;
    logic                    w_fade_tick;
    logic [NUM_LED-1:0]      w_pwm;
    logic [NUM_LED-1:0]      w_pending;

    // With PWM_DIV == 1 the terminal count is 0, so the tick is permanently
    // asserted and pwm_cnt advances every cycle.
    assign w_pwm_tick  = (r_pwm_pre == c_pwm_term);
    assign w_fade_tick = (r_fade_pre == c_fade_term);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_pre  <= '0;
            r_fade_pre <= '0;
            r_pwm_cnt  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_pwm_pre  <= w_pwm_tick  ? '0 : r_pwm_pre  + c_pwm_pre_w'(1);
            r_fade_pre <= w_fade_tick ? '0 : r_fade_pre + c_fade_pre_w'(1);
            if (w_pwm_tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            end
            r_busy     <= |w_pending;
        end
    end

    for (genvar g = 0; g < NUM_LED; g++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_req       (led_req[g]),
            .i_max_level (max_level),
            .i_fade_en   (fade_en),
            .i_fade_tick (w_fade_tick),
            .i_pwm_cnt   (r_pwm_cnt),
            .o_pwm       (w_pwm[g]),
            .o_pending   (w_pending[g])
        );
    end

    assign led_pwm = w_pwm;
    assign busy    = r_busy;

endmodule : led_fade_driver
`default_nettype wire

// File: tb/tb_led_fade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_fade_driver
//  Description : Self-checking bench for led_fade_driver with PWM_DIV=1 and
//                FADE_DIV=4: directed vector table plus multi-cycle ramp,
//                duty-cycle and reset-abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_fade_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led_req;
    logic [7:0] max_level;
    logic       fade_en;
    wire  [3:0] led_pwm;
    wire        busy;

    int n_tests = 0;
    int n_fail  = 0;

    led_fade_driver #(
        .NUM_LED  (4),
        .PWM_BITS (8),
        .PWM_DIV  (1),
        .FADE_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .led_req   (led_req),
        .max_level (max_level),
        .fade_en   (fade_en),
        .led_pwm   (led_pwm),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] maxl;
        logic       fen;
        int         cyc;
        logic       every;
        logic [3:0] epwm;
        logic       ebusy;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // Steps until busy is low; returns the step count, or -1 on timeout.
    task automatic wait_settle(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (busy === 1'b0) begin
                k = i;
                break;
            end
        end
    endtask

    // Counts led_pwm[0] highs and cycles with any other channel high.
    task automatic duty(input int n, output int ones, output int others);
        ones   = 0;
        others = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (led_pwm[0] === 1'b1) ones++;
            if (led_pwm[3:1] !== 3'b000) others++;
        end
    endtask

    initial begin
        int k;
        int ones;
        int others;

        //             rst   req      maxl   fen  cyc every epwm     ebusy
        vecs[0] = '{1'b1, 4'hF,    8'hFF, 1'b0, 5, 1'b1, 4'h0,    1'b0};
        vecs[1] = '{1'b0, 4'hF,    8'h00, 1'b0, 3, 1'b1, 4'h0,    1'b0};
        vecs[2] = '{1'b0, 4'hF,    8'h00, 1'b1, 8, 1'b1, 4'h0,    1'b0};
        vecs[3] = '{1'b0, 4'hF,    8'hFF, 1'b0, 1, 1'b0, 4'h0,    1'b0};
        vecs[4] = '{1'b0, 4'hF,    8'hFF, 1'b0, 1, 1'b0, 4'hF,    1'b0};
        vecs[5] = '{1'b0, 4'b0101, 8'hFF, 1'b0, 2, 1'b0, 4'b0101, 1'b0};
        vecs[6] = '{1'b0, 4'h0,    8'hFF, 1'b1, 1, 1'b0, 4'b0101, 1'b1};
        vecs[7] = '{1'b0, 4'h0,    8'hFF, 1'b0, 2, 1'b0, 4'h0,    1'b0};
        vecs[8] = '{1'b0, 4'b1000, 8'hFF, 1'b0, 1, 1'b0, 4'h0,    1'b0};
        vecs[9] = '{1'b1, 4'b1000, 8'hFF, 1'b0, 1, 1'b0, 4'h0,    1'b0};

        rst       = 1'b1;
        led_req   = 4'h0;
        max_level = 8'h00;
        fade_en   = 1'b0;
        #1;

        for (int v = 0; v < 10; v++) begin
            rst       = vecs[v].rst;
            led_req   = vecs[v].req;
            max_level = vecs[v].maxl;
            fade_en   = vecs[v].fen;
            for (int c = 1; c <= vecs[v].cyc; c++) begin
                step();
                if (vecs[v].every || c == vecs[v].cyc) begin
                    check($sformatf("vec%0d_c%0d_pwm", v, c), 32'(led_pwm), 32'(vecs[v].epwm));
                    check($sformatf("vec%0d_c%0d_busy", v, c), 32'(busy), 32'(vecs[v].ebusy));
                end
            end
        end
        rst = 1'b0;

        // Jump to half brightness: exactly 128 of every 256 counts high.
        fade_en   = 1'b0;
        led_req   = 4'b0001;
        max_level = 8'h80;
        step();
        check("half_busy", 32'(busy), 32'd0);
        step();
        duty(256, ones, others);
        check("half_duty", 32'(ones), 32'd128);
        check("half_others", 32'(others), 32'd0);

        // Full fade-in from reset: 255 ticks of 4 cycles.
        led_req   = 4'h0;
        max_level = 8'hFF;
        fade_en   = 1'b1;
        do_reset(5);
        led_req = 4'b0001;
        wait_settle(1100, k);
        check("fadein_cycles", 32'(k), 32'd1020);
        step();
        duty(256, ones, others);
        check("fadein_full_duty", 32'(ones), 32'd256);
        check("fadein_busy", 32'(busy), 32'd0);

        // Fade in for 100 ticks, then fade back out to 0.
        led_req = 4'h0;
        do_reset(1);
        led_req = 4'b0001;
        repeat (400) step();
        check("ramp100_busy", 32'(busy), 32'd1);
        led_req = 4'h0;
        wait_settle(500, k);
        check("fadeout_cycles", 32'(k), 32'd400);
        step();
        duty(256, ones, others);
        check("fadeout_duty", 32'(ones), 32'd0);
        check("fadeout_busy", 32'(busy), 32'd0);

        // One-cycle reset at level 0x40 aborts the ramp and restarts it.
        do_reset(1);
        led_req = 4'b0001;
        repeat (256) step();
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_pwm", 32'(led_pwm), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        wait_settle(1100, k);
        check("restart_cycles", 32'(k), 32'd1020);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_led_fade_driver
`default_nettype wire
